// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: four-phase FETCH/DECODE/EXECUTE/WRITEBACK sequencer and
// instruction decoder. Latches one instruction into IR per sequence, drives
// register-file and ALU controls from IR, flags illegal encodings and counts
// retired (legal, written-back) instructions.
module multicycle_ctrl #(
  parameter int DataSize = 32,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DataSize-1:0] instruction,
  input  logic                instr_valid,
  output logic                enable_fetch,
  output logic                enable_read,
  output logic [4:0]          read_addr1,
  output logic [4:0]          read_addr2,
  output logic                enable_execute,
  output logic [2:0]          alu_op,
  output logic                src2_imm,
  output logic [DataSize-1:0] imm,
  output logic                enable_write,
  output logic [4:0]          write_addr,
  output logic                illegal,
  output logic [CntWidth-1:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLL  = 3'd5;
  localparam logic [2:0] OP_ROTR = 3'd6;
  localparam logic [2:0] OP_MOV  = 3'd7;

  state_t                state_q, state_d;
  logic [DataSize-1:0]   ir_q;
  logic [CntWidth-1:0]   retired_q;
  logic                  legal;
  logic [2:0]            dec_alu_op;
  logic                  dec_src2_imm;
  logic [DataSize-1:0]   dec_imm;

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state: only FETCH waits, the other phases last exactly one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // IR loads only on the FETCH->DECODE edge, so later instruction changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                ir_q <= '0;
    else if (state_q == S_FETCH && instr_valid) ir_q <= instruction;
  end

  // Decode purely from IR; illegal encodings leave ALU controls and imm at zero
  always_comb begin
    legal        = 1'b1;
    dec_alu_op   = OP_ADD;
    dec_src2_imm = 1'b0;
    dec_imm      = '0;
    if (ir_q[31]) begin
      legal = 1'b0;
    end else begin
      case (ir_q[30:25])
        6'b101000: begin  // ADDI
          dec_alu_op   = OP_ADD;
          dec_src2_imm = 1'b1;
          dec_imm      = {{(DataSize-15){ir_q[14]}}, ir_q[14:0]};
        end
        6'b101100: begin  // ORI
          dec_alu_op   = OP_OR;
          dec_src2_imm = 1'b1;
          dec_imm      = {{(DataSize-15){1'b0}}, ir_q[14:0]};
        end
        6'b101011: begin  // XORI
          dec_alu_op   = OP_XOR;
          dec_src2_imm = 1'b1;
          dec_imm      = {{(DataSize-15){1'b0}}, ir_q[14:0]};
        end
        6'b100010: begin  // MOVI
          dec_alu_op   = OP_MOV;
          dec_src2_imm = 1'b1;
          dec_imm      = {{(DataSize-20){ir_q[19]}}, ir_q[19:0]};
        end
        6'b100000: begin  // ALU group, function in IR[4:0]
          case (ir_q[4:0])
            5'b00000: dec_alu_op = OP_ADD;
            5'b00001: dec_alu_op = OP_SUB;
            5'b00010: dec_alu_op = OP_AND;
            5'b00100: dec_alu_op = OP_OR;
            5'b00011: dec_alu_op = OP_XOR;
            5'b01000: begin
              dec_alu_op   = OP_SLL;
              dec_src2_imm = 1'b1;
              dec_imm      = {{(DataSize-5){1'b0}}, ir_q[14:10]};
            end
            5'b01011: begin
              dec_alu_op   = OP_ROTR;
              dec_src2_imm = 1'b1;
              dec_imm      = {{(DataSize-5){1'b0}}, ir_q[14:10]};
            end
            default: legal = 1'b0;
          endcase
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Retire count advances on WRITEBACK->FETCH for legal instructions, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         retired_q <= '0;
    else if (state_q == S_WB && legal) retired_q <= retired_q + 1'b1;
  end

  // Phase strobes and decode fields; the write strobe is gated by legality
  always_comb begin
    enable_fetch   = (state_q == S_FETCH);
    enable_read    = (state_q == S_DECODE);
    enable_execute = (state_q == S_EXEC);
    enable_write   = (state_q == S_WB) && legal;
    illegal        = (state_q == S_WB) && !legal;
    read_addr1     = ir_q[19:15];
    read_addr2     = ir_q[14:10];
    write_addr     = ir_q[24:20];
    alu_op         = dec_alu_op;
    src2_imm       = dec_src2_imm;
    imm            = dec_imm;
    retired        = retired_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the expected decode
// of each issued instruction; a negedge monitor follows the phase sequence,
// pops at DECODE and checks decode fields, write strobe, illegal and retire count.
module tb_multicycle_ctrl;
  localparam int CW = 4;  // small counter so the wrap is reached quickly

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic          enable_fetch, enable_read, enable_execute, enable_write;
  logic          src2_imm, illegal;
  logic [4:0]    read_addr1, read_addr2, write_addr;
  logic [2:0]    alu_op;
  logic [31:0]   imm;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.DataSize(32), .CntWidth(CW)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .enable_fetch(enable_fetch), .enable_read(enable_read),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .enable_execute(enable_execute), .alu_op(alu_op), .src2_imm(src2_imm),
    .imm(imm), .enable_write(enable_write), .write_addr(write_addr),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        legal;
    logic [2:0]  alu;
    logic        s2;
    logic [31:0] imm;
    logic [4:0]  ra, rb, rt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set table with plain arithmetic
  function automatic exp_t model(input logic [31:0] ir);
    exp_t e;
    int   u15, u20, op, fn;
    e = '0;
    e.ra = ir[19:15]; e.rb = ir[14:10]; e.rt = ir[24:20];
    e.legal = 1'b1;
    u15 = int'(ir[14:0]);
    u20 = int'(ir[19:0]);
    op  = int'(ir[30:25]);
    fn  = int'(ir[4:0]);
    if (ir[31]) e.legal = 1'b0;
    else if (op == 40) begin e.alu = 3'd0; e.s2 = 1'b1; e.imm = 32'((u15 >= 16384) ? u15 - 32768 : u15); end
    else if (op == 44) begin e.alu = 3'd3; e.s2 = 1'b1; e.imm = 32'(u15); end
    else if (op == 43) begin e.alu = 3'd4; e.s2 = 1'b1; e.imm = 32'(u15); end
    else if (op == 34) begin e.alu = 3'd7; e.s2 = 1'b1; e.imm = 32'((u20 >= 524288) ? u20 - 1048576 : u20); end
    else if (op == 32) begin
      if      (fn == 0)  e.alu = 3'd0;
      else if (fn == 1)  e.alu = 3'd1;
      else if (fn == 2)  e.alu = 3'd2;
      else if (fn == 4)  e.alu = 3'd3;
      else if (fn == 3)  e.alu = 3'd4;
      else if (fn == 8)  begin e.alu = 3'd5; e.s2 = 1'b1; e.imm = 32'(ir[14:10]); end
      else if (fn == 11) begin e.alu = 3'd6; e.s2 = 1'b1; e.imm = 32'(ir[14:10]); end
      else e.legal = 1'b0;
    end else e.legal = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: r[30:25] = 6'h28;
      1: r[30:25] = 6'h2C;
      2: r[30:25] = 6'h2B;
      3: r[30:25] = 6'h22;
      4, 5, 6, 7: r[30:25] = 6'h20;
      default: ;
    endcase
    if (r[30:25] == 6'h20) begin
      k = $urandom_range(0, 7);
      case (k)
        0: r[4:0] = 5'd0;
        1: r[4:0] = 5'd1;
        2: r[4:0] = 5'd2;
        3: r[4:0] = 5'd3;
        4: r[4:0] = 5'd4;
        5: r[4:0] = 5'd8;
        6: r[4:0] = 5'd11;
        default: ;
      endcase
    end
    r[31] = ($urandom_range(0, 9) == 0);
    return r;
  endfunction

  // Monitor: phase sequencing, decode checks and the retire count
  int          prev_ph = 0;
  logic [CW-1:0] exp_ret = '0;
  exp_t        cur;
  always @(negedge clk) begin
    int ph, n, eph;
    if (reset) begin
      prev_ph = 0; exp_ret = '0; cur = '0;
    end else begin
      n  = int'(enable_fetch) + int'(enable_read) + int'(enable_execute);
      ph = enable_fetch ? 0 : enable_read ? 1 : enable_execute ? 2 : 3;
      if (n > 1) chk("phase_onehot", 32'(n), 32'd1);
      eph = (prev_ph == 0) ? ((ph == 1) ? 1 : 0) : (prev_ph + 1) % 4;
      chk("phase_seq", 32'(ph), 32'(eph));
      chk("retired", 32'(retired), 32'(exp_ret));
      if (ph == 1) begin
        chk("decode_has_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
      if (ph != 0) begin
        chk("read_addr1", 32'(read_addr1), 32'(cur.ra));
        chk("read_addr2", 32'(read_addr2), 32'(cur.rb));
        chk("write_addr", 32'(write_addr), 32'(cur.rt));
        if (cur.legal) begin
          chk("alu_op", 32'(alu_op), 32'(cur.alu));
          chk("src2_imm", 32'(src2_imm), 32'(cur.s2));
          if (cur.s2) chk("imm", imm, cur.imm);
        end
      end
      if (ph == 3) begin
        chk("enable_write_wb", 32'(enable_write), 32'(cur.legal));
        chk("illegal_wb", 32'(illegal), 32'(!cur.legal));
        if (cur.legal) exp_ret = exp_ret + 1'b1;
      end else begin
        chk("enable_write_idle", 32'(enable_write), 32'd0);
        chk("illegal_idle", 32'(illegal), 32'd0);
      end
      prev_ph = ph;
    end
  end

  // Issue one instruction after 'gap' idle FETCH cycles; returns at the WRITEBACK negedge
  task automatic issue(input logic [31:0] ir, input int gap);
    int budget;
    repeat (gap) begin @(negedge clk); instr_valid = 1'b0; instruction = $urandom; end
    budget = 0;
    while (!enable_fetch && budget < 10) begin
      @(negedge clk); instr_valid = 1'b0; budget++;
    end
    if (!enable_fetch) chk("fetch_reached", 32'(enable_fetch), 32'd1);
    instruction = ir; instr_valid = 1'b1;
    exp_q.push_back(model(ir));
    repeat (3) begin
      @(negedge clk);
      instruction = $urandom;
      instr_valid = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] ra, input logic [14:0] lo);
    return {1'b0, op, rt, ra, lo};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction = '0;
    repeat (3) @(negedge clk);
    chk("rst_fetch", 32'(enable_fetch), 32'd1);
    chk("rst_read", 32'(enable_read), 32'd0);
    chk("rst_exec", 32'(enable_execute), 32'd0);
    chk("rst_write", 32'(enable_write), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_alu_src2", {28'd0, alu_op, src2_imm}, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_addrs", {17'd0, read_addr1, read_addr2, write_addr}, 32'd0);
    reset = 1'b0;

    // Directed cases
    issue(32'h5000000D, 0);                                 // ADDI imm 13
    issue(mk(6'h28, 5'd1, 5'd2, 15'h7FFF), 0);              // ADDI -1
    issue(mk(6'h2C, 5'd4, 5'd5, 15'h7FFF), 1);              // ORI 0x7FFF
    issue(mk(6'h2B, 5'd6, 5'd7, 15'h4001), 0);              // XORI
    issue({1'b0, 6'h22, 5'd2, 20'h00010}, 0);               // MOVI 0x10
    issue({1'b0, 6'h22, 5'd3, 20'h80000}, 0);               // MOVI negative
    issue({1'b0, 6'h20, 5'd3, 5'd0, 5'd1, 5'd0, 5'd0}, 0);  // ADD
    issue({1'b0, 6'h20, 5'd9, 5'd1, 5'd4, 5'd0, 5'd8}, 0);  // SLLI 4
    issue({1'b0, 6'h20, 5'd9, 5'd1, 5'd8, 5'd0, 5'd11}, 0); // ROTRI 8
    issue({1'b0, 6'h3F, 5'd5, 20'h12345}, 0);               // illegal op
    issue({1'b1, 6'h28, 25'h1}, 0);                         // IR[31] set
    issue({1'b0, 6'h20, 5'd1, 5'd1, 5'd1, 5'd0, 5'd5}, 5);  // bad funct after long idle

    // Random traffic; more than 2^CW legal retirements exercises the wrap
    for (int i = 0; i < 150; i++) issue(rand_ir(), $urandom_range(0, 3));

    // Reset landing in WRITEBACK of a legal ADD
    issue({1'b0, 6'h20, 5'd7, 5'd1, 5'd2, 5'd0, 5'd0}, 0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_write", 32'(enable_write), 32'd0);
    chk("midrst_fetch", 32'(enable_fetch), 32'd1);
    chk("midrst_retired", 32'(retired), 32'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) issue(rand_ir(), $urandom_range(0, 2));

    @(negedge clk); instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Four-phase sequencer and decoder for the single-issue datapath inside `top`. It latches one 32-bit instruction per sequence and walks it through FETCH, DECODE, EXECUTE and WRITEBACK. In each phase it drives the register-file read/write controls, the ALU operation select, the operand-B source select and the extended immediate. It also flags illegal encodings and counts retired instructions.

## Interface
- `DataSize`, default 32: datapath and instruction width.
- `CntWidth`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `instruction`  in  DataSize: instruction word. Sampled only in FETCH.
- `instr_valid`  in  1: `instruction` is valid this cycle.
- `enable_fetch`  out  1: high in FETCH.
- `enable_read`  out  1: high in DECODE.
- `read_addr1`  out  5: source register ra, IR[19:15].
- `read_addr2`  out  5: source register rb, IR[14:10].
- `enable_execute`  out  1: high in EXECUTE.
- `alu_op`  out  3: ALU operation. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 ROTR, 7 MOV (pass B).
- `src2_imm`  out  1: 1 selects `imm` as operand B; 0 selects the rb read data.
- `imm`  out  DataSize: extended immediate.
- `enable_write`  out  1: register-file write strobe.
- `write_addr`  out  5: destination register rt, IR[24:20].
- `illegal`  out  1: one-cycle pulse in WRITEBACK for an undecodable IR.
- `retired`  out  CntWidth: count of legal instructions written back.

## Operation
- Internal IR register; it loads on the FETCH→DECODE edge. All decode outputs derive from IR, never from `instruction`.
- The state machine, one state per cycle except FETCH:
  - FETCH: stays in FETCH while `instr_valid`=0. With `instr_valid`=1 it loads IR and moves to DECODE.
  - DECODE → EXECUTE → WRITEBACK → FETCH, unconditionally.
- Decode, with op = IR[30:25]:
  - 101000 ADDI: alu_op ADD, src2_imm=1, imm = sign-extended IR[14:0].
  - 101100 ORI: alu_op OR, imm = zero-extended IR[14:0].
  - 101011 XORI: alu_op XOR, imm = zero-extended IR[14:0].
  - 100010 MOVI: alu_op MOV, imm = sign-extended IR[19:0].
  - 100000 ALU group, selected by IR[4:0]:
    - 00000 ADD, 00001 SUB, 00010 AND, 00100 OR, 00011 XOR: register form, src2_imm=0.
    - 01000 SLLI, 01011 ROTRI: src2_imm=1, imm = zero-extended IR[14:10].
- Illegal encodings: IR[31]=1, any other op, or any other IR[4:0] in the ALU group.
  - An illegal IR still takes all four phases.
  - `enable_write` stays 0, `illegal` pulses, `retired` does not change.
- `enable_write` = (state==WRITEBACK) & legal.
- `retired` increments on the WRITEBACK→FETCH edge when legal. It wraps from 2^CntWidth−1 to 0.
- `alu_op`, `src2_imm`, `imm`, `read_addr*` and `write_addr` hold stable from DECODE through WRITEBACK.

## Timing
- Reset values:
  - State = FETCH and IR = 0, so `enable_fetch`=1.
  - All other enables = 0, `illegal`=0, `retired`=0.
  - `alu_op`=0, `src2_imm`=0, `imm`=0, all addresses 0.
- Latency: `instr_valid` is sampled high at edge N.
  - DECODE spans N..N+1, EXECUTE spans N+1..N+2, WRITEBACK spans N+2..N+3.
  - The register file writes at edge N+3.
  - FETCH is active again at N+3; a back-to-back instruction can be latched at edge N+4.
  - Throughput is therefore one instruction per 4 cycles.
- Changes on `instruction` outside FETCH are ignored.
- Reset asserted mid-sequence aborts immediately. No write occurs, even when reset lands in WRITEBACK, and `retired` clears.
- `instr_valid` held high continuously: the block latches a new instruction at every FETCH.

## Test plan
- Reset, then 0_101000_00000_00000_000000000001101 (ADDI) with `instr_valid`=1:
  - DECODE: alu_op=0, src2_imm=1, imm=0x0000000D, read_addr1=0.
  - WRITEBACK: enable_write=1, write_addr=0.
  - After WRITEBACK: retired=1.
- Immediate extension:
  - ADDI with imm15=0x7FFF → imm=0xFFFFFFFF.
  - ORI with imm15=0x7FFF → imm=0x00007FFF.
  - MOVI 0_100010_00010_00000000000000010000 → alu_op=7, imm=0x10, write_addr=2.
- ALU group:
  - 0_100000_00011_00000_00001_00000_00000 (ADD) → src2_imm=0, read_addr1=0, read_addr2=1, write_addr=3.
  - SLLI with IR[14:10]=4 → alu_op=5, imm=4.
  - ROTRI with IR[14:10]=8 → alu_op=6, imm=8.
- Illegal IR, op 111111 → all four phases run, illegal=1 only in WRITEBACK, enable_write stays 0, retired unchanged.
- Flow control: `instr_valid`=0 for 5 cycles → remains in FETCH with no enables toggling. Then toggle `instruction` during EXECUTE → decode outputs are unchanged.
- Reset asserted during WRITEBACK of a legal ADD → enable_write drops asynchronously, retired=0, state=FETCH.
